// File: rtl/sifh_frame_sequencer.sv
// Frame sequencer for the SiFH histogram builder: clear, coarse pass, peak latch,
// clear, fine pass, then hold the frame result until downstream accepts it.
module sifh_frame_sequencer #(
  parameter int unsigned DATA_NUM        = 2,
  parameter int unsigned PIXEL_NUM       = 4,
  parameter int unsigned ACQ_NUM         = 3,
  parameter int unsigned BIN_NUM_PER_HIS = 16,
  parameter int unsigned DRAIN_CYC       = 3,
  localparam int unsigned CLR_D = PIXEL_NUM * BIN_NUM_PER_HIS,
  localparam int unsigned PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int unsigned CLR_W = (CLR_D > 1) ? $clog2(CLR_D) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [PIX_W-1:0] pix_idx,
  output logic             pass_fine,
  output logic             clr_en,
  output logic [CLR_W-1:0] clr_addr,
  output logic             pk_latch,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned IN_W  = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int unsigned ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACQ, S_DRAIN, S_LATCH, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [CLR_W-1:0] clr_addr_q, clr_addr_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic in_ready_q, in_ready_d;
  logic pass_fine_q, pass_fine_d;
  logic clr_en_q, clr_en_d;
  logic pk_latch_q, pk_latch_d;
  logic res_valid_q, res_valid_d;
  logic busy_q, busy_d;
  logic wr_en_c;

  // A write happens whenever the registered ready meets a live sample.
  assign wr_en_c = in_valid & in_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    pix_d       = pix_q;
    acq_d       = acq_q;
    drn_d       = drn_q;
    clr_addr_d  = clr_addr_q;
    frame_cnt_d = frame_cnt_q;
    pass_fine_d = pass_fine_q;
    in_ready_d  = 1'b0;
    clr_en_d    = 1'b0;
    pk_latch_d  = 1'b0;
    res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          clr_en_d    = 1'b1;
          clr_addr_d  = '0;
          pass_fine_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_addr_q == CLR_W'(CLR_D - 1)) begin
          state_d    = S_ACQ;
          in_ready_d = 1'b1;
          clr_addr_d = '0;
        end else begin
          clr_en_d   = 1'b1;
          clr_addr_d = clr_addr_q + CLR_W'(1);
        end
      end
      S_ACQ: begin
        in_ready_d = 1'b1;
        if (wr_en_c) begin
          if (in_cnt_q == IN_W'(DATA_NUM - 1)) begin
            in_cnt_d = '0;
            if (pix_q == PIX_W'(PIXEL_NUM - 1)) begin
              pix_d = '0;
              if (acq_q == ACQ_W'(ACQ_NUM - 1)) begin
                acq_d      = '0;
                drn_d      = '0;
                in_ready_d = 1'b0;
                state_d    = S_DRAIN;
              end else begin
                acq_d = acq_q + ACQ_W'(1);
              end
            end else begin
              pix_d = pix_q + PIX_W'(1);
            end
          end else begin
            in_cnt_d = in_cnt_q + IN_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_CYC - 1)) begin
          drn_d = '0;
          if (pass_fine_q) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
          end else begin
            state_d    = S_LATCH;
            pk_latch_d = 1'b1;
          end
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_LATCH: begin
        pass_fine_d = 1'b1;
        in_cnt_d    = '0;
        pix_d       = '0;
        acq_d       = '0;
        drn_d       = '0;
        clr_addr_d  = '0;
        clr_en_d    = 1'b1;
        state_d     = S_CLEAR;
      end
      S_DONE: begin
        if (res_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          pass_fine_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      in_cnt_d    = '0;
      pix_d       = '0;
      acq_d       = '0;
      drn_d       = '0;
      clr_addr_d  = '0;
      frame_cnt_d = frame_cnt_q;
      pass_fine_d = 1'b0;
      in_ready_d  = 1'b0;
      clr_en_d    = 1'b0;
      pk_latch_d  = 1'b0;
      res_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      pix_q       <= '0;
      acq_q       <= '0;
      drn_q       <= '0;
      clr_addr_q  <= '0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      pass_fine_q <= 1'b0;
      clr_en_q    <= 1'b0;
      pk_latch_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      pix_q       <= pix_d;
      acq_q       <= acq_d;
      drn_q       <= drn_d;
      clr_addr_q  <= clr_addr_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= in_ready_d;
      pass_fine_q <= pass_fine_d;
      clr_en_q    <= clr_en_d;
      pk_latch_q  <= pk_latch_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_c;
  assign pix_idx   = pix_q;
  assign pass_fine = pass_fine_q;
  assign clr_en    = clr_en_q;
  assign clr_addr  = clr_addr_q;
  assign pk_latch  = pk_latch_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule
